// File: rtl/rssb_seq.sv
// Multi-cycle sequencer for the RSSB one-instruction core: fetch, operand load,
// subtract and write-back over a single req/ack memory port.
module rssb_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             halted,
  output logic [WIDTH-1:0] opc,
  output logic [WIDTH-1:0] oacc,
  output logic [WIDTH-1:0] oop1,
  output logic [WIDTH-1:0] omem,
  output logic [WIDTH-1:0] osub
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  state_t           state;
  logic             borrow;
  logic [WIDTH-1:0] next_pc;

  function automatic logic [WIDTH-1:0] wrap_sub(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a - b;
  endfunction

  // Borrow skips the following instruction word; both steps wrap at 2^WIDTH.
  function automatic logic [WIDTH-1:0] pc_advance(input logic [WIDTH-1:0] pc,
                                                  input logic             skip);
    return pc + (skip ? WIDTH'(2) : WIDTH'(1));
  endfunction

  always_comb begin
    next_pc = pc_advance(opc, borrow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      borrow    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      opc       <= '0;
      oacc      <= '0;
      oop1      <= '0;
      omem      <= '0;
      osub      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= opc;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            oop1 <= mem_rdata;
            if (mem_rdata == '1) begin
              state   <= S_HALT;
              busy    <= 1'b0;
              halted  <= 1'b1;
              mem_req <= 1'b0;
            end else begin
              // Request stays high: the operand load follows with no idle cycle.
              state    <= S_LOAD;
              mem_addr <= mem_rdata;
            end
          end
        end
        S_LOAD: begin
          if (mem_ack) begin
            omem    <= mem_rdata;
            state   <= S_EXEC;
            mem_req <= 1'b0;
          end
        end
        S_EXEC: begin
          osub      <= wrap_sub(omem, oacc);
          borrow    <= (omem < oacc);
          state     <= S_STORE;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= oop1;
          mem_wdata <= wrap_sub(omem, oacc);
        end
        S_STORE: begin
          if (mem_ack) begin
            oacc     <= osub;
            opc      <= next_pc;
            state    <= S_FETCH;
            mem_we   <= 1'b0;
            mem_addr <= next_pc;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          halted  <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rssb_seq.sv
// Self-checking bench for rssb_seq: memory responder with random ack delays and
// an instruction-level reference model of the RSSB machine.
module tb_rssb_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stray_ack = 1'b0;
  logic       mem_req, mem_we, mem_ack, busy, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] opc, oacc, oop1, omem, osub;

  logic [7:0] mem  [256];
  logic [7:0] prog [256];
  logic       do_load = 1'b0;
  int         wait_cnt = 0;
  int         wr_count = 0;
  int         min_delay = 0;
  int         max_delay = 0;

  logic [7:0] rmem [256];
  logic [7:0] rpc, racc;
  int         rsteps;

  int checks = 0;
  int errors = 0;

  rssb_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .halted(halted),
    .opc(opc), .oacc(oacc), .oop1(oop1), .omem(omem), .osub(osub)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req ? (wait_cnt == 0) : stray_ack;

  // Memory responder: owns the memory array and the per-transaction wait count.
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 256; i++) mem[i] = prog[i];
      wait_cnt <= int'($urandom_range(max_delay, min_delay));
    end else if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_count <= wr_count + 1;
      end
      wait_cnt <= int'($urandom_range(max_delay, min_delay));
    end else if (mem_req && wait_cnt > 0) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'd0;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) rmem[i] = prog[i];
    rpc = 8'd0;
    racc = 8'd0;
    rsteps = 0;
    do_load = 1'b1;
    tick();
    do_load = 1'b0;
  endtask

  // One architectural instruction of the RSSB machine.
  task automatic ref_step(output bit hlt);
    logic [7:0] op, v, s;
    op = rmem[rpc];
    if (op == 8'hFF) begin
      hlt = 1'b1;
      return;
    end
    hlt = 1'b0;
    v = rmem[op];
    s = v - racc;
    rmem[op] = s;
    rpc = rpc + ((v < racc) ? 8'd2 : 8'd1);
    racc = s;
    rsteps++;
  endtask

  task automatic ref_run();
    bit h;
    h = 1'b0;
    for (int k = 0; k < 1000 && !h; k++) ref_step(h);
  endtask

  task automatic run_until_halt(input int budget, output int cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!halted && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_req, mem_we, busy, halted, mem_addr, mem_wdata, opc, oacc, oop1, omem, osub} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b busy=%b halted=%b addr=%h wdata=%h opc=%h acc=%h op1=%h mem=%h sub=%h, required all 0",
               mem_req, mem_we, busy, halted, mem_addr, mem_wdata, opc, oacc, oop1, omem, osub);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_and_start: busy=%b req=%b, required 0 0", busy, mem_req);
    end
    clear_prog();
    prog[0] = 8'd9;
    load_program();
    stray_ack = 1'b1;
    tick();
    tick();
    tick();
    stray_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || oop1 !== 8'd0 || omem !== 8'd0) begin
      errors++;
      $display("FAIL stray_ack_idle: req=%b busy=%b op1=%h mem=%h, required 0 0 00 00",
               mem_req, busy, oop1, omem);
    end
  endtask

  task automatic test_basic();
    int wr0, bad;
    do_reset();
    min_delay = 0;
    max_delay = 0;
    clear_prog();
    prog[0] = 8'd10; prog[10] = 8'd5;
    prog[1] = 8'd11; prog[11] = 8'd3;
    prog[3] = 8'hFF;
    load_program();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd10 || mem_wdata !== 8'd5) begin
      errors++;
      $display("FAIL store_request: busy=%b req=%b we=%b addr=%h wdata=%h, required 1 1 1 0a 05",
               busy, mem_req, mem_we, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (mem[10] !== 8'd5 || oacc !== 8'd5 || osub !== 8'd5 || opc !== 8'd1) begin
      errors++;
      $display("FAIL first_instr: mem10=%0d acc=%0d sub=%0d pc=%0d, required 5 5 5 1",
               mem[10], oacc, osub, opc);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (mem[11] !== 8'd254 || oacc !== 8'd254 || osub !== 8'd254 || opc !== 8'd3 || halted !== 1'b0) begin
      errors++;
      $display("FAIL borrow_skip: mem11=%0d acc=%0d sub=%0d pc=%0d halted=%b, required 254 254 254 3 0",
               mem[11], oacc, osub, opc, halted);
    end
    wr0 = wr_count;
    tick();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || opc !== 8'd3 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_detect: halted=%b busy=%b pc=%0d req=%b, required 1 0 3 0",
               halted, busy, opc, mem_req);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) start = 1'b1;
      if (i == 7) start = 1'b0;
      tick();
      if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || wr_count != wr0 || opc !== 8'd3) begin
      errors++;
      $display("FAIL halt_quiet: bad_cycles=%0d writes=%0d pc=%0d, required 0 0 3",
               bad, wr_count - wr0, opc);
    end
  endtask

  task automatic test_random_delay();
    int cycles, bad;
    bit pend, pwe;
    logic [7:0] paddr, pwdata;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      min_delay = 0;
      max_delay = (it < 2) ? 0 : 3;
      clear_prog();
      if (it == 0 || it == 2) begin
        prog[0] = 8'd10; prog[10] = 8'd5;
        prog[1] = 8'd11; prog[11] = 8'd3;
        prog[3] = 8'hFF;
      end else begin
        for (int i = 0; i < 16; i++) prog[i] = 8'(32 + $urandom_range(15, 0));
        prog[16] = 8'hFF;
        prog[17] = 8'hFF;
        for (int i = 32; i < 48; i++) prog[i] = 8'($urandom);
      end
      load_program();
      ref_run();
      start = 1'b1;
      tick();
      cycles = 0;
      while (!halted && cycles < 2000) begin
        start = 1'($urandom_range(1, 0));
        pend = mem_req && !mem_ack;
        pwe = mem_we;
        paddr = mem_addr;
        pwdata = mem_wdata;
        tick();
        cycles++;
        if (pend) begin
          checks++;
          if (mem_req !== 1'b1 || mem_we !== pwe || mem_addr !== paddr || (pwe && mem_wdata !== pwdata)) begin
            errors++;
            $display("FAIL req_stable it%0d: req=%b we=%b addr=%h wdata=%h, required 1 %b %h %h",
                     it, mem_req, mem_we, mem_addr, mem_wdata, pwe, paddr, pwdata);
          end
        end
      end
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) bad++;
      checks++;
      if (halted !== 1'b1 || bad != 0 || opc !== rpc || oacc !== racc) begin
        errors++;
        $display("FAIL program_result it%0d: halted=%b mem_diffs=%0d pc=%h acc=%h, required 1 0 %h %h",
                 it, halted, bad, opc, oacc, rpc, racc);
      end
      if (max_delay == 0) begin
        checks++;
        if (cycles != 4 * rsteps + 1) begin
          errors++;
          $display("FAIL zero_wait_latency it%0d: cycles=%0d, required %0d", it, cycles, 4 * rsteps + 1);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit h;
    int bad;
    // Borrow taken at pc=254: the accumulator is loaded with 9 at pc=253 first.
    do_reset();
    min_delay = 0;
    max_delay = 0;
    clear_prog();
    prog[253] = 8'd100;
    prog[100] = 8'd9;
    load_program();
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 255; k++) begin
      tick(); tick(); tick(); tick();
      ref_step(h);
      if (opc !== rpc || oacc !== racc) bad++;
      if (k == 253) begin
        checks++;
        if (opc !== 8'd254) begin
          errors++;
          $display("FAIL reach_254: pc=%0d, required 254", opc);
        end
      end
    end
    checks++;
    if (bad != 0 || opc !== 8'd0 || oacc !== 8'd247) begin
      errors++;
      $display("FAIL wrap_borrow: step_diffs=%0d pc=%0d acc=%0d, required 0 0 247", bad, opc, oacc);
    end
    // No borrow at pc=255: every instruction is 0 - 0.
    do_reset();
    clear_prog();
    load_program();
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      tick(); tick(); tick(); tick();
      ref_step(h);
      if (opc !== rpc || oacc !== racc) bad++;
      if (k == 254) begin
        checks++;
        if (opc !== 8'd255) begin
          errors++;
          $display("FAIL reach_255: pc=%0d, required 255", opc);
        end
      end
    end
    checks++;
    if (bad != 0 || opc !== 8'd0 || oacc !== 8'd0) begin
      errors++;
      $display("FAIL wrap_noborrow: step_diffs=%0d pc=%0d acc=%0d, required 0 0 0", bad, opc, oacc);
    end
  endtask

  task automatic test_reset_mid();
    bit h, found;
    int cycles, bad;
    do_reset();
    min_delay = 3;
    max_delay = 3;
    clear_prog();
    prog[0] = 8'd10; prog[10] = 8'd5;
    prog[1] = 8'd11; prog[11] = 8'd3;
    prog[3] = 8'hFF;
    load_program();
    ref_step(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (mem_req && !mem_we && mem_addr == 8'd11 && !mem_ack) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || opc !== 8'd1) begin
      errors++;
      $display("FAIL reach_load_wait: found=%b pc=%0d, required 1 1", found, opc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_req, mem_we, busy, halted, mem_addr, mem_wdata, opc, oacc, oop1, omem, osub} !== '0) begin
      errors++;
      $display("FAIL reset_mid: req=%b busy=%b halted=%b addr=%h pc=%h acc=%h op1=%h mem=%h sub=%h, required all 0",
               mem_req, busy, halted, mem_addr, opc, oacc, oop1, omem, osub);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b req=%b, required 0 0", busy, mem_req);
    end
    rpc = 8'd0;
    racc = 8'd0;
    ref_run();
    min_delay = 0;
    run_until_halt(2000, cycles);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) bad++;
    checks++;
    if (halted !== 1'b1 || bad != 0 || opc !== rpc || oacc !== racc) begin
      errors++;
      $display("FAIL rerun_after_reset: halted=%b mem_diffs=%0d pc=%h acc=%h, required 1 0 %h %h",
               halted, bad, opc, oacc, rpc, racc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_random_delay();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
